vector_vector_alu_v2: RTL

Parametrised successor to the vector-vector ALU stage of the trace-processing chain. It combines each incoming N-lane vector with an operand vector from an internal vector register file (VVRF), using a per-chain firmware op, with signed fixed-point arithmetic and optional saturation. It can cache the result back into the VVRF, with read-after-write forwarding. It sits between the filter/reduce stages and the data packer, and is configured over the shared configId/configData byte bus.

---
 rtl/vector_vector_alu_v2.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/vector_vector_alu_v2.sv
// Vector-vector ALU stage: combines each N-lane input vector with a VVRF operand using per-chain firmware ops.
// Two-cycle fixed latency, full throughput, optional result caching into the VVRF with RAW forwarding.
module vector_vector_alu_v2 #(
    parameter int N                  = 8,
    parameter int DATA_WIDTH         = 32,
    parameter int FRAC_BITS          = 16,
    parameter int MAX_CHAINS         = 4,
    parameter int VVVRF_SIZE         = 8,
    parameter int PERSONAL_CONFIG_ID = 0,
    localparam int CW = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tracing,
    input  logic                    valid_in,
    input  logic [1:0]              eof_in,
    input  logic [1:0]              bof_in,
    input  logic [CW-1:0]           chainId_in,
    input  logic [7:0]              configId,
    input  logic [7:0]              configData,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic [CW-1:0]           chainId_out,
    output logic                    valid_out,
    output logic [1:0]              eof_out,
    output logic [1:0]              bof_out
);
    localparam int W  = DATA_WIDTH;
    localparam int VW = N * DATA_WIDTH;
    localparam int AW = $clog2(VVVRF_SIZE);
    localparam logic [2:0] TBL_OP    = 3'd0;
    localparam logic [2:0] TBL_ADDR  = 3'd1;
    localparam logic [2:0] TBL_COND  = 3'd2;
    localparam logic [2:0] TBL_CACHE = 3'd3;
    localparam logic [2:0] TBL_CADDR = 3'd4;
    localparam logic [2:0] TBL_DONE  = 3'd5;
    localparam logic [CW-1:0] LAST_ENT = CW'(MAX_CHAINS - 1);
    localparam logic signed [2*W-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    function automatic logic [W-1:0] narrow(input logic signed [2*W-1:0] x, input logic sat);
        logic [W-1:0] r;
        if (!sat)             r = x[W-1:0];
        else if (x > SAT_MAX) r = SAT_MAX[W-1:0];
        else if (x < SAT_MIN) r = SAT_MIN[W-1:0];
        else                  r = x[W-1:0];
        return r;
    endfunction

    // op[4] is the saturate flag, op[3:0] the operation code
    function automatic logic [W-1:0] lane_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [4:0] op);
        logic signed [2*W-1:0] ax, bx, wide;
        logic [W-1:0] r;
        ax   = {{W{a[W-1]}}, a};
        bx   = {{W{b[W-1]}}, b};
        wide = {(2*W){1'b0}};
        case (op[3:0])
            4'd1: begin wide = ax + bx; r = narrow(wide, op[4]); end
            4'd2: begin wide = (ax * bx) >>> FRAC_BITS; r = narrow(wide, op[4]); end
            4'd3: begin wide = ax - bx; r = narrow(wide, op[4]); end
            4'd4: r = ($signed(a) > $signed(b)) ? a : b;
            4'd5: r = ($signed(a) < $signed(b)) ? a : b;
            default: r = a;
        endcase
        return r;
    endfunction

    function automatic logic cond_hit(input logic [7:0] cond, input logic [1:0] eof, input logic [1:0] bof);
        logic r;
        case (cond)
            8'd0: r = 1'b1;
            8'd1: r = eof[0];
            8'd2: r = !eof[0];
            8'd3: r = bof[0];
            8'd4: r = !bof[0];
            8'd5: r = eof[1];
            8'd6: r = !eof[1];
            8'd7: r = bof[1];
            8'd8: r = !bof[1];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [4:0]    fw_op_r    [MAX_CHAINS];
    logic [AW-1:0] fw_addr_r  [MAX_CHAINS];
    logic [7:0]    fw_cond_r  [MAX_CHAINS];
    logic          fw_cache_r [MAX_CHAINS];
    logic [AW-1:0] fw_caddr_r [MAX_CHAINS];
    logic [2:0]    cfg_tbl_r;
    logic [CW-1:0] cfg_ent_r;
    logic [VW-1:0] vvrf_r     [VVVRF_SIZE];

    logic          s1_valid_r, s1_cache_r;
    logic [VW-1:0] s1_vec_r, s1_opnd_r;
    logic [1:0]    s1_eof_r, s1_bof_r;
    logic [CW-1:0] s1_chain_r;
    logic [4:0]    s1_op_r;
    logic [7:0]    s1_cond_r;
    logic [AW-1:0] s1_caddr_r;

    logic [VW-1:0] result_s, opnd_s;
    logic [AW-1:0] rd_addr_s;
    logic          wr_en_s, cfg_sel_s;

    assign cfg_sel_s = (configId == 8'(PERSONAL_CONFIG_ID));
    assign wr_en_s   = s1_valid_r && s1_cache_r && tracing;
    assign rd_addr_s = fw_addr_r[chainId_in];

    // Operand fetch: forward the item in stage 2 when it is writing the address being read
    always_comb begin
        opnd_s = vvrf_r[rd_addr_s];
        if (wr_en_s && (s1_caddr_r == rd_addr_s)) opnd_s = result_s;
        else                                     opnd_s = vvrf_r[rd_addr_s];
    end

    // Lane arithmetic; a false condition passes the input vector through unchanged
    always_comb begin
        result_s = s1_vec_r;
        if (cond_hit(s1_cond_r, s1_eof_r, s1_bof_r)) begin
            for (int i = 0; i < N; i++) begin
                result_s[i*W +: W] = lane_calc(s1_vec_r[i*W +: W], s1_opnd_r[i*W +: W], s1_op_r);
            end
        end else begin
            result_s = s1_vec_r;
        end
    end

    // Config byte stream: table-major walk over the firmware entries, saturating at the end
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_tbl_r <= 3'd0;
            cfg_ent_r <= {CW{1'b0}};
            for (int i = 0; i < MAX_CHAINS; i++) begin
                fw_op_r[i]    <= 5'd0;
                fw_addr_r[i]  <= {AW{1'b0}};
                fw_cond_r[i]  <= 8'd0;
                fw_cache_r[i] <= 1'b0;
                fw_caddr_r[i] <= {AW{1'b0}};
            end
        end else if (!tracing) begin
            if (!cfg_sel_s) begin
                cfg_tbl_r <= 3'd0;
                cfg_ent_r <= {CW{1'b0}};
            end else if (cfg_tbl_r < TBL_DONE) begin
                case (cfg_tbl_r)
                    TBL_OP:    fw_op_r[cfg_ent_r]    <= {configData[7], configData[3:0]};
                    TBL_ADDR:  fw_addr_r[cfg_ent_r]  <= configData[AW-1:0];
                    TBL_COND:  fw_cond_r[cfg_ent_r]  <= configData;
                    TBL_CACHE: fw_cache_r[cfg_ent_r] <= configData[0];
                    TBL_CADDR: fw_caddr_r[cfg_ent_r] <= configData[AW-1:0];
                    default:   fw_op_r[cfg_ent_r]    <= fw_op_r[cfg_ent_r];
                endcase
                if (cfg_ent_r == LAST_ENT) begin
                    cfg_ent_r <= {CW{1'b0}};
                    cfg_tbl_r <= cfg_tbl_r + 3'd1;
                end else begin
                    cfg_ent_r <= cfg_ent_r + CW'(1);
                end
            end
        end
    end

    // Vector register file with a single write port from stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VVVRF_SIZE; i++) vvrf_r[i] <= {VW{1'b0}};
        end else if (wr_en_s) begin
            vvrf_r[s1_caddr_r] <= result_s;
        end
    end

    // Stage 1: capture item, firmware entry and operand
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_vec_r   <= {VW{1'b0}};
            s1_opnd_r  <= {VW{1'b0}};
            s1_eof_r   <= 2'b00;
            s1_bof_r   <= 2'b00;
            s1_chain_r <= {CW{1'b0}};
            s1_op_r    <= 5'd0;
            s1_cond_r  <= 8'd0;
            s1_cache_r <= 1'b0;
            s1_caddr_r <= {AW{1'b0}};
        end else begin
            s1_valid_r <= valid_in;
            s1_vec_r   <= vector_in;
            s1_opnd_r  <= opnd_s;
            s1_eof_r   <= eof_in;
            s1_bof_r   <= bof_in;
            s1_chain_r <= chainId_in;
            s1_op_r    <= fw_op_r[chainId_in];
            s1_cond_r  <= fw_cond_r[chainId_in];
            s1_cache_r <= fw_cache_r[chainId_in];
            s1_caddr_r <= fw_caddr_r[chainId_in];
        end
    end

    // Stage 2: register results; valid only while tracing
    always_ff @(posedge clk) begin
        if (rst) begin
            vector_out  <= {VW{1'b0}};
            chainId_out <= {CW{1'b0}};
            valid_out   <= 1'b0;
            eof_out     <= 2'b00;
            bof_out     <= 2'b00;
        end else begin
            vector_out  <= result_s;
            chainId_out <= s1_chain_r;
            valid_out   <= s1_valid_r && tracing;
            eof_out     <= s1_eof_r;
            bof_out     <= s1_bof_r;
        end
    end
endmodule
